fetch_stage: RTL and testbench
==============================

Name: fetch_stage

Overview:
- Instruction-fetch stage directly upstream of the 16x16 instruction memory.
- Owns the program counter and drives the memory's 4-bit read address, which the memory decodes combinationally.
- Captures the returned 16-bit instruction into the IF/ID pipeline register for the decoder.
- Handles stall, flush/redirect from execute (branch resolution), and zero-penalty unconditional jumps by predecoding opcode 1011.

Parameters:
- ADDR_W, 4, PC / instruction-memory address width (16 entries).
- INSTR_W, 16, instruction width; fields are opcode[15:12], first[11:8], second[7:4], dest/imm[3:0].
- RESET_PC, 4'd0, PC value loaded on reset.
- JUMP_OPCODE, 4'b1011, opcode predecoded as an unconditional absolute jump to instr[3:0].

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous, active-low reset.
- imem_addr  output  ADDR_W  read address to instruction memory; always equals pc.
- imem_instr  input  INSTR_W  instruction returned combinationally by memory for imem_addr.
- stall  input  1  hazard stall from decode; holds PC and IF/ID register.
- redirect_valid  input  1  branch-taken / flush request from execute.
- redirect_addr  input  ADDR_W  redirect target PC.
- if_instr  output  INSTR_W  registered instruction to decode.
- if_pc  output  ADDR_W  registered PC of if_instr.
- if_pc_plus1  output  ADDR_W  registered (if_pc+1) mod 16, for branch-offset base.
- if_valid  output  1  if_instr is a real, non-flushed instruction.

Behaviour:
- Reset (asynchronous on rst_n low):
  - pc = RESET_PC; if_instr = 16'h0000; if_pc = 0; if_pc_plus1 = 1; if_valid = 0.
  - imem_addr follows pc, so it reads RESET_PC during reset.
- imem_addr = pc combinationally; no extra latency.
- An instruction at pc appears on if_* one clock edge after it is addressed.
- Per rising edge, priority is redirect > stall > jump predecode > sequential:
  - Redirect (redirect_valid=1):
    - pc <= redirect_addr.
    - if_valid <= 0 (the instruction fetched this cycle is wrong-path).
    - if_instr, if_pc, if_pc_plus1 load the current fetch values; they are don't-care while if_valid=0.
    - Overrides stall, because execute flushes the stalled slot.
  - Stall (stall=1, no redirect):
    - pc, if_instr, if_pc, if_pc_plus1 and if_valid all hold.
    - imem_addr stays constant.
  - Jump predecode (imem_instr[15:12]==JUMP_OPCODE, no stall, no redirect):
    - IF/ID loads the jump with if_valid <= 1; decode treats it as a no-op.
    - pc <= imem_instr[3:0]. No bubble: the target is fetched the next cycle.
  - Sequential (otherwise):
    - IF/ID <= {imem_instr, pc, pc+1}; if_valid <= 1.
    - pc <= pc+1, wrapping 15 -> 0.
- Width rules:
  - All PC arithmetic is modulo 2^ADDR_W; no carry out.
  - Branch/BNE (1000) and other opcodes are not interpreted here; only JUMP_OPCODE is predecoded.
- Boundaries:
  - Jump to self (pc=k, instr[3:0]=k) loops, issuing the jump every cycle with if_valid=1.
  - Redirect to the current pc is legal: it refetches and drops one slot.
  - A redirect arriving in the same cycle as a fetched jump wins; the jump is dropped (if_valid=0).
  - Stall asserted for N cycles means the if_* outputs are stable for N cycles.
  - Reset mid-operation returns to the reset values immediately; the first valid output comes on the first edge after rst_n rises, carrying if_pc=RESET_PC.

Test Plan:
- Reset then run with mem[0..7] = 16'hA016, 16'h9516, 16'h5085, 16'h6587, 16'h8072, 16'h5010, 16'h5012, 16'hB000 -> if_pc sequence 0,1,…,7 then 0 with no bubble; if_instr matches the memory; if_valid=1 from the first edge.
- Stall held 3 cycles while if_pc=2 -> if_pc=2, if_instr=16'h5085 stable for 3 cycles; imem_addr=3 constant; resumes with if_pc=3.
- redirect_valid=1 with redirect_addr=5 while pc=4 -> next edge if_valid=0; the following edge gives if_pc=5, if_instr=16'h5010.
- redirect_valid and stall together, redirect_addr=1 -> redirect wins: if_valid=0, then if_pc=1.
- Fill mem[15]=16'h5000 with no jump -> pc wraps 15 -> 0; if_pc_plus1=0 when if_pc=15.
- Assert rst_n low mid-run at pc=6 -> outputs immediately 0 / if_valid=0, imem_addr=0; after release, if_pc=0 on the first edge.

Source files
------------

// File: rtl/fetch_stage_if.sv
// rtl/fetch_stage_if.sv - fetch stage bus: instruction memory, control from decode/execute, IF/ID outputs
interface fetch_stage_if #(
  parameter int ADDR_W  = 4,
  parameter int INSTR_W = 16
);
  logic [ADDR_W-1:0]  imem_addr;
  logic [INSTR_W-1:0] imem_instr;
  logic               stall;
  logic               redirect_valid;
  logic [ADDR_W-1:0]  redirect_addr;
  logic [INSTR_W-1:0] if_instr;
  logic [ADDR_W-1:0]  if_pc;
  logic [ADDR_W-1:0]  if_pc_plus1;
  logic               if_valid;

  // fetch stage side
  modport master (
    output imem_addr, if_instr, if_pc, if_pc_plus1, if_valid,
    input  imem_instr, stall, redirect_valid, redirect_addr
  );

  // memory / pipeline environment side
  modport slave (
    input  imem_addr, if_instr, if_pc, if_pc_plus1, if_valid,
    output imem_instr, stall, redirect_valid, redirect_addr
  );
endinterface

// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - program counter, jump predecode and IF/ID register for the instruction fetch stage
module fetch_stage #(
  parameter int               ADDR_W      = 4,
  parameter int               INSTR_W     = 16,
  parameter logic [ADDR_W-1:0] RESET_PC   = '0,
  parameter logic [3:0]       JUMP_OPCODE = 4'b1011
) (
  input logic            clk,
  input logic            rst_n,
  fetch_stage_if.master  bus
);

  localparam logic [ADDR_W-1:0] ONE = ADDR_W'(1);

  logic [ADDR_W-1:0]  pc;
  logic [ADDR_W-1:0]  pc_inc;
  logic [ADDR_W-1:0]  pc_next;
  logic               is_jump;
  logic               load;
  logic [INSTR_W-1:0] if_instr_q;
  logic [ADDR_W-1:0]  if_pc_q;
  logic [ADDR_W-1:0]  if_pc_plus1_q;
  logic               if_valid_q;

  // Memory decodes the address combinationally, so the PC drives it directly.
  assign bus.imem_addr   = pc;
  assign bus.if_instr    = if_instr_q;
  assign bus.if_pc       = if_pc_q;
  assign bus.if_pc_plus1 = if_pc_plus1_q;
  assign bus.if_valid    = if_valid_q;

  // Modulo-2^ADDR_W increment; the carry is intentionally dropped.
  assign pc_inc  = pc + ONE;
  assign is_jump = (bus.imem_instr[INSTR_W-1 -: 4] == JUMP_OPCODE);
  // A redirect flushes even a stalled slot, so it also forces a load.
  assign load    = bus.redirect_valid || !bus.stall;

  // Next PC: redirect beats stall, stall beats jump predecode, jump beats pc+1.
  always_comb begin
    pc_next = pc;
    if (bus.redirect_valid) begin
      pc_next = bus.redirect_addr;
    end else if (!bus.stall) begin
      pc_next = is_jump ? bus.imem_instr[ADDR_W-1:0] : pc_inc;
    end
  end

  // PC and IF/ID register; a redirect loads the wrong-path fetch but marks it invalid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc            <= RESET_PC;
      if_instr_q    <= '0;
      if_pc_q       <= '0;
      if_pc_plus1_q <= ONE;
      if_valid_q    <= 1'b0;
    end else if (load) begin
      pc            <= pc_next;
      if_instr_q    <= bus.imem_instr;
      if_pc_q       <= pc;
      if_pc_plus1_q <= pc_inc;
      if_valid_q    <= !bus.redirect_valid;
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// tb/tb_fetch_stage.sv - scoreboard bench for fetch_stage with directed vectors
module tb_fetch_stage;

  typedef struct {
    logic        v;
    logic [3:0]  pc;
    logic [3:0]  p1;
    logic [15:0] instr;
    logic [3:0]  addr;
  } exp_t;

  logic        clk;
  logic        rst_n;
  logic [15:0] mem [16];
  exp_t        q [$];
  exp_t        last;
  logic        upd;
  int          checks;
  int          errors;

  fetch_stage_if #(.ADDR_W(4), .INSTR_W(16)) bus ();

  fetch_stage #(
    .ADDR_W(4), .INSTR_W(16), .RESET_PC(4'd0), .JUMP_OPCODE(4'b1011)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  assign bus.imem_instr = mem[bus.imem_addr];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Record whether the edge just taken should have updated IF/ID.
  always @(posedge clk) begin
    upd = rst_n && (bus.redirect_valid || !bus.stall);
  end

  // Monitor: pop on every updating edge, otherwise require held outputs.
  always @(negedge clk) begin
    if (rst_n) begin
      if (upd) begin
        if (q.size() == 0) begin
          chk("queue_underflow", 32'd1, 32'd0);
        end else begin
          last = q.pop_front();
          chk("if_valid", 32'(bus.if_valid), 32'(last.v));
          if (last.v) begin
            chk("if_pc", 32'(bus.if_pc), 32'(last.pc));
            chk("if_pc_plus1", 32'(bus.if_pc_plus1), 32'(last.p1));
            chk("if_instr", 32'(bus.if_instr), 32'(last.instr));
          end
          chk("imem_addr", 32'(bus.imem_addr), 32'(last.addr));
        end
      end else begin
        chk("stall_valid", 32'(bus.if_valid), 32'(last.v));
        chk("stall_pc", 32'(bus.if_pc), 32'(last.pc));
        chk("stall_instr", 32'(bus.if_instr), 32'(last.instr));
        chk("stall_addr", 32'(bus.imem_addr), 32'(last.addr));
      end
    end
  end

  // One cycle of stimulus; the expected IF/ID state after the edge is queued if it updates.
  task automatic e(input logic st, input logic rd, input logic [3:0] ra,
                   input logic v, input logic [3:0] pc, input logic [3:0] p1,
                   input logic [15:0] instr, input logic [3:0] addr);
    exp_t x;
    bus.stall          = st;
    bus.redirect_valid = rd;
    bus.redirect_addr  = ra;
    x.v = v; x.pc = pc; x.p1 = p1; x.instr = instr; x.addr = addr;
    if (rd || !st) q.push_back(x);
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_rst_valid"}, 32'(bus.if_valid), 32'd0);
    chk({tag, "_rst_pc"}, 32'(bus.if_pc), 32'd0);
    chk({tag, "_rst_p1"}, 32'(bus.if_pc_plus1), 32'd1);
    chk({tag, "_rst_instr"}, 32'(bus.if_instr), 32'h0000);
    chk({tag, "_rst_addr"}, 32'(bus.imem_addr), 32'd0);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    upd    = 1'b0;
    last   = '{v: 1'b0, pc: 4'd0, p1: 4'd1, instr: 16'h0000, addr: 4'd0};
    rst_n  = 1'b0;
    bus.stall = 1'b0;
    bus.redirect_valid = 1'b0;
    bus.redirect_addr = 4'd0;
    mem[0] = 16'hA016; mem[1] = 16'h9516; mem[2] = 16'h5085; mem[3] = 16'h6587;
    mem[4] = 16'h8072; mem[5] = 16'h5010; mem[6] = 16'h5012; mem[7] = 16'hB000;
    for (int i = 8; i < 15; i++) mem[i] = 16'h5000 + 16'(i);
    mem[15] = 16'h5000;

    repeat (2) @(posedge clk);
    #1;
    chk_reset("init");
    @(negedge clk);
    #1;
    rst_n = 1'b1;

    // Sequential run, valid from the first edge
    e(0, 0, 0, 1, 4'd0, 4'd1, 16'hA016, 4'd1);
    e(0, 0, 0, 1, 4'd1, 4'd2, 16'h9516, 4'd2);
    e(0, 0, 0, 1, 4'd2, 4'd3, 16'h5085, 4'd3);
    // Stall three cycles while if_pc=2
    e(1, 0, 0, 0, 4'd0, 4'd0, 16'h0000, 4'd0);
    e(1, 0, 0, 0, 4'd0, 4'd0, 16'h0000, 4'd0);
    e(1, 0, 0, 0, 4'd0, 4'd0, 16'h0000, 4'd0);
    e(0, 0, 0, 1, 4'd3, 4'd4, 16'h6587, 4'd4);
    // Redirect to 5 while pc=4
    e(0, 1, 4'd5, 0, 4'd4, 4'd5, 16'h8072, 4'd5);
    e(0, 0, 0, 1, 4'd5, 4'd6, 16'h5010, 4'd6);
    e(0, 0, 0, 1, 4'd6, 4'd7, 16'h5012, 4'd7);
    // Jump at 7 to 0, no bubble
    e(0, 0, 0, 1, 4'd7, 4'd8, 16'hB000, 4'd0);
    e(0, 0, 0, 1, 4'd0, 4'd1, 16'hA016, 4'd1);
    // Redirect with stall, to the current pc
    e(1, 1, 4'd1, 0, 4'd1, 4'd2, 16'h9516, 4'd1);
    e(0, 0, 0, 1, 4'd1, 4'd2, 16'h9516, 4'd2);
    e(0, 0, 0, 1, 4'd2, 4'd3, 16'h5085, 4'd3);
    e(0, 0, 0, 1, 4'd3, 4'd4, 16'h6587, 4'd4);
    e(0, 0, 0, 1, 4'd4, 4'd5, 16'h8072, 4'd5);
    e(0, 0, 0, 1, 4'd5, 4'd6, 16'h5010, 4'd6);
    e(0, 0, 0, 1, 4'd6, 4'd7, 16'h5012, 4'd7);
    // Redirect beats the jump fetched at 7
    e(0, 1, 4'd2, 0, 4'd7, 4'd8, 16'hB000, 4'd2);
    e(0, 0, 0, 1, 4'd2, 4'd3, 16'h5085, 4'd3);
    // Remove the jump and run through the 15 -> 0 wrap
    mem[7] = 16'h5007;
    e(0, 0, 0, 1, 4'd3, 4'd4, 16'h6587, 4'd4);
    e(0, 0, 0, 1, 4'd4, 4'd5, 16'h8072, 4'd5);
    e(0, 0, 0, 1, 4'd5, 4'd6, 16'h5010, 4'd6);
    e(0, 0, 0, 1, 4'd6, 4'd7, 16'h5012, 4'd7);
    e(0, 0, 0, 1, 4'd7, 4'd8, 16'h5007, 4'd8);
    for (int i = 8; i < 15; i++)
      e(0, 0, 0, 1, 4'(i), 4'(i + 1), 16'h5000 + 16'(i), 4'(i + 1));
    e(0, 0, 0, 1, 4'd15, 4'd0, 16'h5000, 4'd0);
    e(0, 0, 0, 1, 4'd0, 4'd1, 16'hA016, 4'd1);
    // Jump to self at 2
    mem[2] = 16'hB002;
    e(0, 0, 0, 1, 4'd1, 4'd2, 16'h9516, 4'd2);
    e(0, 0, 0, 1, 4'd2, 4'd3, 16'hB002, 4'd2);
    e(0, 0, 0, 1, 4'd2, 4'd3, 16'hB002, 4'd2);
    mem[2] = 16'h5085;
    e(0, 0, 0, 1, 4'd2, 4'd3, 16'h5085, 4'd3);
    e(0, 0, 0, 1, 4'd3, 4'd4, 16'h6587, 4'd4);
    e(0, 0, 0, 1, 4'd4, 4'd5, 16'h8072, 4'd5);
    e(0, 0, 0, 1, 4'd5, 4'd6, 16'h5010, 4'd6);
    // Asynchronous reset mid-run at pc=6
    @(negedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk_reset("mid");
    @(posedge clk);
    #1;
    chk_reset("hold");
    @(negedge clk);
    #1;
    rst_n = 1'b1;
    e(0, 0, 0, 1, 4'd0, 4'd1, 16'hA016, 4'd1);
    e(0, 0, 0, 1, 4'd1, 4'd2, 16'h9516, 4'd2);
    @(negedge clk);
    #1;
    chk("queue_drained", 32'(q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
